// File: rtl/holiday_lights_gen_pkg.sv
// holiday_lights_gen_pkg
//   Shared definitions for the LED pattern generator: animation mode
//   encodings, the controller state enum and the seed-bit helper.
package holiday_lights_gen_pkg;

  localparam logic [1:0] MODE_ROL   = 2'd0;
  localparam logic [1:0] MODE_ROR   = 2'd1;
  localparam logic [1:0] MODE_PONG  = 2'd2;
  localparam logic [1:0] MODE_BLINK = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // One bit of the seed pattern. The low min(sel+1, width) bits are set.
  // The helper works per bit so that callers of any width can use it.
  function automatic logic seed_bit(input int sel, input int width, input int idx);
    int n;
    n = sel + 1;
    if (n > width) n = width;
    return (idx < n);
  endfunction

endpackage

// File: rtl/holiday_lights_gen_btn_press_ctrl.sv
// btn_press_ctrl
//   Button conditioning for the LED pattern generator.
//   Ports:
//     clk_sys  in   system clock
//     rst_b    in   asynchronous active-low reset
//     button   in   raw push button, active-high, asynchronous to clk_sys
//     press    out  one-cycle pulse on each synchronised rising edge
//     long     out  one-cycle pulse once the button has been held HOLD_CYC cycles
module btn_press_ctrl #(
  parameter int HOLD_CYC = 200000000
) (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic button,
  output logic press,
  output logic long
);

  localparam int HW = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0] HOLD_PRE  = HW'(HOLD_CYC - 2);

  logic [1:0]    sync_q;
  logic          btn_d;
  logic [HW-1:0] hold_cnt;

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      sync_q   <= '0;
      btn_d    <= 1'b0;
      press    <= 1'b0;
      long     <= 1'b0;
      hold_cnt <= '0;
    end else begin
      sync_q <= {sync_q[0], button};
      btn_d  <= sync_q[1];
      press  <= sync_q[1] & ~btn_d;
      // Counter saturates at HOLD_CYC-1; long fires on the cycle it gets there.
      if (!sync_q[1]) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + HW'(1);
      end
      long <= sync_q[1] && (hold_cnt == HOLD_PRE);
    end
  end

endmodule

// File: rtl/holiday_lights_gen.sv
// holiday_lights_gen
//   Parametrised LED pattern generator with rotate-left, rotate-right,
//   ping-pong and blink animations, speed select and button control.
//   Ports:
//     clk_sys  in   system clock
//     rst_b    in   asynchronous active-low reset
//     button   in   raw push button (press: run/pause, long press: idle)
//     switch   in   seed length select, seed = switch+1 ones (clamped)
//     mode     in   animation mode (see package MODE_*)
//     speed    in   step period = TICK_DIV >> speed (minimum 1)
//     led      out  LED drive, bit 0 = rightmost
//     running  out  high while in RUN
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_IDLE  | led follows seed; press starts the animation
//   ST_RUN   | tick divider counts, led steps per mode
//   ST_PAUSE | led, tick, dir and blink phase frozen
module holiday_lights_gen
  import holiday_lights_gen_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int SEL_W    = 3,
  parameter int TICK_DIV = 100000000,
  parameter int HOLD_CYC = 200000000
) (
  input  logic             clk_sys,
  input  logic             rst_b,
  input  logic             button,
  input  logic [SEL_W-1:0] switch,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  output logic [WIDTH-1:0] led,
  output logic             running
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic             press;
  logic             long;
  state_t           state;
  logic [TW-1:0]    tick;
  logic [WIDTH-1:0] pat;
  logic             dir;      // 0 = left, 1 = right
  logic             phase;
  logic [1:0]       mode_q;

  logic [WIDTH-1:0] seed;
  logic [31:0]      period;
  logic [31:0]      period_m1;
  logic             step;
  logic             enter_blink;
  logic             leave_blink;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] pat_eff;
  logic             phase_eff;
  logic [WIDTH-1:0] nxt_led;
  logic             nxt_dir;
  logic             nxt_phase;

  btn_press_ctrl #(.HOLD_CYC(HOLD_CYC)) u_btn (
    .clk_sys (clk_sys),
    .rst_b   (rst_b),
    .button  (button),
    .press   (press),
    .long    (long)
  );

  always_comb begin
    seed = '0;
    for (int i = 0; i < WIDTH; i++) begin
      seed[i] = seed_bit(int'(switch), WIDTH, i);
    end

    period = 32'(TICK_DIV) >> speed;
    if (period == 32'd0) period = 32'd1;
    period_m1 = period - 32'd1;
    // >= so that a speed-up past the current count steps on the next cycle.
    step = (32'(tick) >= period_m1);

    enter_blink = (mode == MODE_BLINK) && (mode_q != MODE_BLINK);
    leave_blink = (mode != MODE_BLINK) && (mode_q == MODE_BLINK);
    cur         = (leave_blink && (led == '0)) ? pat : led;
    pat_eff     = enter_blink ? led : pat;
    phase_eff   = enter_blink ? 1'b0 : phase;

    nxt_led   = cur;
    nxt_dir   = dir;
    nxt_phase = phase_eff;
    case (mode)
      MODE_ROL: nxt_led = {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ROR: nxt_led = {cur[0], cur[WIDTH-1:1]};
      MODE_PONG: begin
        if (&cur) begin
          nxt_led = cur;
        end else if (!dir && cur[WIDTH-1]) begin
          nxt_dir = 1'b1;
          nxt_led = cur >> 1;
        end else if (dir && cur[0]) begin
          nxt_dir = 1'b0;
          nxt_led = cur << 1;
        end else begin
          nxt_led = dir ? (cur >> 1) : (cur << 1);
        end
      end
      default: begin
        nxt_phase = ~phase_eff;
        nxt_led   = phase_eff ? pat_eff : '0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      state   <= ST_IDLE;
      running <= 1'b0;
      led     <= '0;
      pat     <= '0;
      tick    <= '0;
      dir     <= 1'b0;
      phase   <= 1'b0;
      mode_q  <= MODE_ROL;
    end else begin
      case (state)
        ST_IDLE: begin
          led    <= seed;
          mode_q <= mode;
          if (press && !long) begin
            state   <= ST_RUN;
            running <= 1'b1;
            tick    <= '0;
            pat     <= seed;
            dir     <= 1'b0;
            phase   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (long) begin
            state   <= ST_IDLE;
            running <= 1'b0;
            led     <= seed;
          end else if (press) begin
            state   <= ST_PAUSE;
            running <= 1'b0;
          end else begin
            mode_q <= mode;
            pat    <= pat_eff;
            if (step) begin
              tick  <= '0;
              led   <= nxt_led;
              dir   <= nxt_dir;
              phase <= nxt_phase;
            end else begin
              tick  <= tick + TW'(1);
              led   <= cur;
              phase <= phase_eff;
            end
          end
        end
        ST_PAUSE: begin
          if (long) begin
            state   <= ST_IDLE;
            led     <= seed;
          end else if (press) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule
